// File: rtl/player_ctrl.sv
// Frame-synchronous game-state and player-movement controller.
// Samples buttons, switches and collision once per vertical sync, advances
// the TITLE/PLAY/DEAD/PAUSE state machine and updates sprite position/room.
module player_ctrl #(
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned SPRITE_W    = 8,
    parameter int unsigned SPRITE_H    = 8,
    parameter int unsigned STEP        = 2,
    parameter int unsigned START_X     = 16,
    parameter int unsigned START_Y     = 236,
    parameter int unsigned NUM_ROOMS   = 8,
    parameter int unsigned DEAD_FRAMES = 60
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       vs_vga,
    input  logic [3:0] BUTTON,
    input  logic [3:0] SWITCH,
    input  logic       hit,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic [2:0] room,
    output logic [1:0] state,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        DEAD  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int unsigned DW = $clog2(DEAD_FRAMES + 1);

    localparam logic [10:0]   LIM_X     = 11'(X_MAX - SPRITE_W + 1);
    localparam logic [10:0]   LIM_Y     = 11'(Y_MAX - SPRITE_H + 1);
    localparam logic [10:0]   STEP_N    = 11'(STEP);
    localparam logic [10:0]   STEP_D    = 11'(STEP << 1);
    localparam logic [9:0]    SPAWN_X   = 10'(START_X);
    localparam logic [9:0]    SPAWN_Y   = 10'(START_Y);
    localparam logic [2:0]    ROOM_LAST = 3'(NUM_ROOMS - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_FRAMES - 1);

    state_t        st;
    logic          vs_s1, vs_s2, vs_prev;
    logic [3:0]    btn_s1, btn_s2;
    logic [1:0]    sw_s1, sw_s2;
    logic [3:0]    btn_hist;
    logic [3:0]    deb_prev;
    logic [3:0]    deb;
    logic          hit_lat;
    logic          hit_now;
    logic [DW-1:0] dead_cnt;
    logic [10:0]   s;
    logic [10:0]   x_w, y_w;
    logic [10:0]   nx, ny;
    logic [2:0]    nroom;
    logic          unused_sw;

    assign unused_sw = ^SWITCH[3:2];
    assign state     = st;

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            vs_s1  <= vs_vga;
            vs_s2  <= vs_s1;
            btn_s1 <= BUTTON;
            btn_s2 <= btn_s1;
            sw_s1  <= SWITCH[1:0];
            sw_s2  <= sw_s1;
        end
    end

    // One-cycle frame tick on a falling edge of synchronized vsync
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            vs_prev    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_prev    <= vs_s2;
            frame_tick <= vs_prev & ~vs_s2;
        end
    end

    // Collision latch: holds hits seen between ticks, cleared by each tick
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            hit_lat <= 1'b0;
        end else if (frame_tick) begin
            hit_lat <= 1'b0;
        end else if (hit) begin
            hit_lat <= 1'b1;
        end
    end

    // a hit in the tick cycle itself still counts for that tick
    assign hit_now = hit_lat | hit;

    // deb uses the current sample plus the one stored at the previous tick
    assign deb = btn_s2 & btn_hist;

    // Next position and room for one frame of movement in PLAY
    always_comb begin
        s     = sw_s2[1] ? STEP_D : STEP_N;
        x_w   = {1'b0, player_x};
        y_w   = {1'b0, player_y};
        nx    = x_w;
        ny    = y_w;
        nroom = room;
        if (deb[0] && !deb[1]) begin
            ny = (y_w < s) ? '0 : y_w - s;
        end else if (deb[1] && !deb[0]) begin
            ny = (y_w + s > LIM_Y) ? LIM_Y : y_w + s;
        end
        if (deb[3] && !deb[2]) begin
            if (x_w + s > LIM_X) begin
                if (room < ROOM_LAST) begin
                    nroom = room + 3'd1;
                    nx    = '0;
                end else begin
                    nx = LIM_X;
                end
            end else begin
                nx = x_w + s;
            end
        end else if (deb[2] && !deb[3]) begin
            if (x_w < s) begin
                if (room != 3'd0) begin
                    nroom = room - 3'd1;
                    nx    = LIM_X;
                end else begin
                    nx = '0;
                end
            end else begin
                nx = x_w - s;
            end
        end
    end

    // Game state machine with registered position/room, evaluated per tick
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            st       <= TITLE;
            player_x <= SPAWN_X;
            player_y <= SPAWN_Y;
            room     <= '0;
            btn_hist <= '0;
            deb_prev <= '0;
            dead_cnt <= '0;
        end else if (frame_tick) begin
            btn_hist <= btn_s2;
            deb_prev <= deb;
            case (st)
                TITLE: begin
                    player_x <= SPAWN_X;
                    player_y <= SPAWN_Y;
                    room     <= '0;
                    if ((deb & ~deb_prev) != 4'd0) begin
                        st <= PLAY;
                    end
                end
                PLAY: begin
                    if (hit_now) begin
                        st       <= DEAD;
                        dead_cnt <= DEAD_LOAD;
                    end else if (sw_s2[0]) begin
                        st <= PAUSE;
                    end else begin
                        player_x <= nx[9:0];
                        player_y <= ny[9:0];
                        room     <= nroom;
                    end
                end
                PAUSE: begin
                    if (!sw_s2[0]) begin
                        st <= PLAY;
                    end
                end
                DEAD: begin
                    if (dead_cnt == '0) begin
                        st       <= TITLE;
                        player_x <= SPAWN_X;
                        player_y <= SPAWN_Y;
                        room     <= '0;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: st <= TITLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed testbench for player_ctrl: drives vsync frames, buttons,
// switches and hit pulses and compares outputs with hand-computed values.
module tb_player_ctrl;

    logic       clk;
    logic       reset;
    logic       vs_vga;
    logic [3:0] BUTTON;
    logic [3:0] SWITCH;
    logic       hit;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [2:0] room;
    logic [1:0] state;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    logic ft_after;

    player_ctrl #(
        .X_MAX(639), .Y_MAX(479), .SPRITE_W(8), .SPRITE_H(8), .STEP(2),
        .START_X(16), .START_Y(236), .NUM_ROOMS(8), .DEAD_FRAMES(60)
    ) dut (
        .clk_50MHz (clk),
        .reset     (reset),
        .vs_vga    (vs_vga),
        .BUTTON    (BUTTON),
        .SWITCH    (SWITCH),
        .hit       (hit),
        .player_x  (player_x),
        .player_y  (player_y),
        .room      (room),
        .state     (state),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int r, input int st);
        check_eq({tag, "_x"}, 32'(player_x), x);
        check_eq({tag, "_y"}, 32'(player_y), y);
        check_eq({tag, "_room"}, 32'(room), r);
        check_eq({tag, "_state"}, 32'(state), st);
    endtask

    // one vsync frame: falling edge, wait (bounded) for the tick, settle high
    task automatic tick();
        logic got;
        got = 1'b0;
        vs_vga = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (frame_tick) got = 1'b1;
        end
        check_eq("tick_seen", 32'(got), 1);
        @(negedge clk);
        ft_after = frame_tick;
        vs_vga = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        vs_vga = 1'b1;
        BUTTON = 4'd0;
        SWITCH = 4'd0;
        hit    = 1'b0;
        repeat (3) @(negedge clk);
        check_pos("reset", 16, 236, 0, 0);
        check_eq("reset_ft", 32'(frame_tick), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // TITLE -> PLAY on a debounced right press, then movement
        BUTTON = 4'b1000;
        tick();
        check_pos("title_t1", 16, 236, 0, 0);
        check_eq("ft_pulse", 32'(ft_after), 0);
        tick();
        check_pos("title_t2", 16, 236, 0, 1);
        tick();
        check_pos("move_18", 18, 236, 0, 1);
        tick();
        check_pos("move_20", 20, 236, 0, 1);
        SWITCH = 4'b0010;
        tick();
        check_pos("move_x2", 24, 236, 0, 1);

        // right edge of room 0 -> room 1
        run_ticks(151);
        check_pos("r0_628", 628, 236, 0, 1);
        SWITCH = 4'b0000;
        tick();
        check_pos("r0_630", 630, 236, 0, 1);
        SWITCH = 4'b0010;
        tick();
        check_pos("r0_to_r1", 0, 236, 1, 1);

        // across to room 7 and clamp at its right edge
        run_ticks(954);
        check_pos("r7_entry", 0, 236, 7, 1);
        run_ticks(157);
        SWITCH = 4'b0000;
        tick();
        check_pos("r7_630", 630, 236, 7, 1);
        tick();
        check_pos("r7_632", 632, 236, 7, 1);
        tick();
        check_pos("r7_clamp", 632, 236, 7, 1);

        // walk left back through the rooms
        BUTTON = 4'b0100;
        SWITCH = 4'b0010;
        tick();
        check_pos("left_first", 632, 236, 7, 1);
        run_ticks(636);
        check_pos("r3_632", 632, 236, 3, 1);
        SWITCH = 4'b0000;
        run_ticks(315);
        check_pos("r3_x2", 2, 236, 3, 1);
        SWITCH = 4'b0010;
        tick();
        check_pos("r3_to_r2", 632, 236, 2, 1);
        run_ticks(158);
        check_pos("r2_x0", 0, 236, 2, 1);
        tick();
        check_pos("r2_to_r1", 632, 236, 1, 1);

        // simultaneous and vertical inputs
        BUTTON = 4'b0011;
        tick();
        check_pos("ud_first", 632, 236, 1, 1);
        tick();
        check_pos("ud_both", 632, 236, 1, 1);
        BUTTON = 4'b1101;
        tick();
        check_pos("lru_first", 632, 232, 1, 1);
        tick();
        check_pos("lru_both", 632, 228, 1, 1);
        BUTTON = 4'b0010;
        tick();
        check_pos("down_first", 632, 228, 1, 1);
        run_ticks(60);
        check_pos("down_468", 632, 468, 1, 1);
        SWITCH = 4'b0000;
        tick();
        check_pos("down_470", 632, 470, 1, 1);
        SWITCH = 4'b0010;
        tick();
        check_pos("down_clamp", 632, 472, 1, 1);
        tick();
        check_pos("down_hold", 632, 472, 1, 1);

        // asynchronous reset mid-PLAY
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_pos("mid_reset", 16, 236, 0, 0);
        check_eq("mid_reset_ft", 32'(frame_tick), 0);
        BUTTON = 4'd0;
        SWITCH = 4'd0;
        vs_vga = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // hit with pause also requested: DEAD wins, then 60 frames to TITLE
        BUTTON = 4'b1000;
        run_ticks(2);
        check_pos("replay", 16, 236, 0, 1);
        run_ticks(2);
        check_pos("replay_20", 20, 236, 0, 1);
        BUTTON = 4'b0000;
        SWITCH = 4'b0001;
        pulse_hit();
        tick();
        check_pos("dead_entry", 20, 236, 0, 2);
        SWITCH = 4'b0000;
        BUTTON = 4'b1000;
        run_ticks(59);
        check_pos("dead_59", 20, 236, 0, 2);
        tick();
        check_pos("dead_done", 16, 236, 0, 0);
        run_ticks(3);
        check_pos("held_title", 16, 236, 0, 0);
        BUTTON = 4'b0000;
        tick();
        BUTTON = 4'b1000;
        tick();
        check_pos("repress_t1", 16, 236, 0, 0);
        tick();
        check_pos("repress_t2", 16, 236, 0, 1);

        // pause ignores buttons and hits
        SWITCH = 4'b0001;
        tick();
        check_pos("pause_entry", 16, 236, 0, 3);
        pulse_hit();
        tick();
        pulse_hit();
        tick();
        check_pos("pause_hold", 16, 236, 0, 3);
        pulse_hit();
        SWITCH = 4'b0000;
        tick();
        check_pos("unpause", 16, 236, 0, 1);
        tick();
        check_pos("resume_move", 18, 236, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
